program_loader: RTL

Upstream boot stage for the 20-bit five-stage pipeline. It accepts a byte stream over a valid/ready handshake and packs every three bytes into one 20-bit instruction word. It writes those words sequentially into instruction memory and zero-fills the unused tail. The pipeline is held in reset until the image is complete, then released.

---
 rtl/program_loader_pkg.sv | 15 +
 rtl/program_loader_byte_packer.sv | 59 +++++
 rtl/program_loader.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared constants and loader state type for the 20-bit pipeline and its boot loader.
package program_loader_pkg;

  localparam int unsigned DATA_WIDTH    = 20;
  localparam int unsigned ADDRESS_WIDTH = 8;
  localparam int unsigned MEM_SIZE      = 256;

  typedef enum logic [1:0] {
    StLoad,
    StFill,
    StRun,
    StErr
  } loader_state_t;

endpackage

// File: rtl/program_loader_byte_packer.sv
// Assembles little-endian byte triples into 20-bit words; a last byte flushes a zero-padded word.
module program_loader_byte_packer
  import program_loader_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  fire_i,
  input  logic [7:0]            byte_i,
  input  logic                  last_i,
  output logic [DATA_WIDTH-1:0] word_o,
  output logic                  word_valid_o
);

  logic [1:0]  k_q, k_d;
  logic [15:0] acc_q, acc_d;

  assign word_valid_o = fire_i && (last_i || (k_q == 2'd2));

  // Only bytes already gathered for this word are used, so padding is implicit.
  always_comb begin
    word_o = '0;
    unique case (k_q)
      2'd0:    word_o = {12'h000, byte_i};
      2'd1:    word_o = {4'h0, byte_i, acc_q[7:0]};
      default: word_o = {byte_i[3:0], acc_q};
    endcase
  end

  always_comb begin
    k_d   = k_q;
    acc_d = acc_q;
    if (clear_i) begin
      k_d = 2'd0;
    end else if (fire_i) begin
      if (word_valid_o) begin
        k_d = 2'd0;
      end else begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd0) begin
          acc_d[7:0] = byte_i;
        end else begin
          acc_d[15:8] = byte_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      k_q   <= 2'd0;
      acc_q <= 16'h0000;
    end else begin
      k_q   <= k_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: streams bytes into instruction memory, zero-fills the tail, then releases the CPU.
module program_loader #(
  parameter int unsigned DATA_WIDTH    = program_loader_pkg::DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH = program_loader_pkg::ADDRESS_WIDTH,
  parameter int unsigned MEM_SIZE      = program_loader_pkg::MEM_SIZE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [7:0]               in_byte,
  input  logic                     in_last,
  output logic                     in_ready,
  input  logic                     reload,
  output logic                     imem_we,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0]    imem_wdata,
  output logic                     cpu_rst,
  output logic                     done,
  output logic                     err_overflow,
  output logic [ADDRESS_WIDTH:0]   word_count
);

  import program_loader_pkg::*;

  localparam logic [ADDRESS_WIDTH:0] MemEnd  = (ADDRESS_WIDTH + 1)'(MEM_SIZE);
  localparam logic [ADDRESS_WIDTH:0] AddrOne = (ADDRESS_WIDTH + 1)'(1);

  loader_state_t state_q, state_d;
  logic armed_q, armed_d;
  logic [ADDRESS_WIDTH:0] addr_q, addr_d, addr_inc;
  logic [ADDRESS_WIDTH:0] wc_q, wc_d;
  logic we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] ia_q, ia_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic cpu_rst_q, cpu_rst_d;
  logic done_q, done_d;
  logic err_q, err_d;

  logic accept, pk_fire, pk_clear, pk_valid;
  logic [DATA_WIDTH-1:0] pk_word;

  // armed_q keeps in_ready low until the first edge after reset is released.
  assign in_ready = armed_q && (state_q == StLoad);
  assign accept   = in_valid && in_ready;
  assign addr_inc = addr_q + AddrOne;

  program_loader_byte_packer u_packer (
    .clk_i        (clk),
    .rst_ni       (rst),
    .clear_i      (pk_clear),
    .fire_i       (pk_fire),
    .byte_i       (in_byte),
    .last_i       (in_last),
    .word_o       (pk_word),
    .word_valid_o (pk_valid)
  );

  always_comb begin
    state_d   = state_q;
    armed_d   = 1'b1;
    addr_d    = addr_q;
    wc_d      = wc_q;
    we_d      = 1'b0;
    ia_d      = ia_q;
    wd_d      = wd_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    err_d     = err_q;
    pk_fire   = 1'b0;
    pk_clear  = 1'b0;

    unique case (state_q)
      StLoad: begin
        if (accept) begin
          if (wc_q == MemEnd) begin
            state_d   = StErr;
            err_d     = 1'b1;
            cpu_rst_d = 1'b1;
          end else begin
            pk_fire = 1'b1;
            if (pk_valid) begin
              we_d   = 1'b1;
              ia_d   = addr_q[ADDRESS_WIDTH-1:0];
              wd_d   = pk_word;
              addr_d = addr_inc;
              wc_d   = wc_q + AddrOne;
              if (in_last) begin
                if (addr_inc < MemEnd) begin
                  state_d = StFill;
                end else begin
                  state_d   = StRun;
                  done_d    = 1'b1;
                  cpu_rst_d = 1'b0;
                end
              end
            end
          end
        end
      end
      StFill: begin
        we_d   = 1'b1;
        ia_d   = addr_q[ADDRESS_WIDTH-1:0];
        wd_d   = '0;
        addr_d = addr_inc;
        if (addr_inc == MemEnd) begin
          state_d   = StRun;
          done_d    = 1'b1;
          cpu_rst_d = 1'b0;
        end
      end
      default: begin
        if (reload) begin
          state_d   = StLoad;
          cpu_rst_d = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
          wc_d      = '0;
          addr_d    = '0;
          ia_d      = '0;
          pk_clear  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StLoad;
      armed_q   <= 1'b0;
      addr_q    <= '0;
      wc_q      <= '0;
      we_q      <= 1'b0;
      ia_q      <= '0;
      wd_q      <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      addr_q    <= addr_d;
      wc_q      <= wc_d;
      we_q      <= we_d;
      ia_q      <= ia_d;
      wd_q      <= wd_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = ia_q;
  assign imem_wdata   = wd_q;
  assign cpu_rst      = cpu_rst_q;
  assign done         = done_q;
  assign err_overflow = err_q;
  assign word_count   = wc_q;

endmodule
